vend_ctrl: RTL and testbench

Top-level vending controller that sequences the coin path, product selection, dispenser and change hopper. It accumulates credit in 5-unit coins, checks each selection against a per-product price table, and runs a req/ack handshake with the dispenser motor. It then pays back change or a refund coin-by-coin through the hopper handshake, and sits between the coin acceptor front end and the mechanical drivers.

---
 rtl/vend_ctrl_pkg.sv | 28 ++
 rtl/vend_ctrl_if.sv | 40 ++++
 rtl/vend_timer.sv | 40 ++++
 rtl/vend_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_vend_ctrl.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vend_ctrl_pkg.sv
// Shared definitions for the vending controller: state encoding, coin units, default prices.
// No logic of its own; latency n/a.
// No flow control; constants and a pure helper function only.
package vend_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CREDIT   = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_CHANGE   = 2'd3
    } state_e;

    // Coin values expressed in 5-units.
    localparam logic [1:0] UNIT5  = 2'd1;
    localparam logic [1:0] UNIT10 = 2'd2;

    // Default price table in 5-units.
    localparam int PRICE0_DEF = 3;
    localparam int PRICE1_DEF = 4;
    localparam int PRICE2_DEF = 5;
    localparam int PRICE3_DEF = 6;

    // Value of the coins presented this cycle; both at once gives 3 units.
    function automatic logic [1:0] coin_units(input logic in5, input logic in10);
        return (in5 ? UNIT5 : 2'd0) + (in10 ? UNIT10 : 2'd0);
    endfunction

endpackage

// File: rtl/vend_ctrl_if.sv
// Bundle of coin, selection, dispenser and hopper signals around the controller.
// Pure wiring; no latency.
// Dispenser and hopper use level req / sampled ack; everything else is single-cycle pulses.
interface vend_ctrl_if
    import vend_ctrl_pkg::*;
#(
    parameter int CREDIT_W = 4
);
    logic                in5;
    logic                in10;
    logic                sel_valid;
    logic [1:0]          sel_id;
    logic                cancel;
    logic                disp_ack;
    logic                chg_ack;
    logic [CREDIT_W-1:0] credit;
    logic                disp_req;
    logic [1:0]          disp_id;
    logic                chg_req;
    logic                chg_type;
    logic                coin_reject;
    logic                insufficient;
    logic                err;
    logic                busy;

    // Controller side: issues dispense/change requests, consumes coins and acks.
    modport master (
        input  in5, in10, sel_valid, sel_id, cancel, disp_ack, chg_ack,
        output credit, disp_req, disp_id, chg_req, chg_type,
        output coin_reject, insufficient, err, busy
    );

    // Machine side: coin acceptor, keypad, dispenser motor and hopper.
    modport slave (
        output in5, in10, sel_valid, sel_id, cancel, disp_ack, chg_ack,
        input  credit, disp_req, disp_id, chg_req, chg_type,
        input  coin_reject, insufficient, err, busy
    );

endinterface

// File: rtl/vend_timer.sv
// Loadable down-counter that flags the last counted cycle of a LOAD_VAL-long window.
// expire is combinational from the count: high in the LOAD_VAL-th enabled cycle after a load.
// No backpressure; load wins over counting and suppresses expire.
module vend_timer
    import vend_ctrl_pkg::*;
#(
    parameter int LOAD_VAL = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire
);
    localparam int W = (LOAD_VAL < 2) ? 1 : $clog2(LOAD_VAL + 1);

    logic [W-1:0] cnt_q, cnt_d;

    // Reload on request, otherwise count down while enabled and stop at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = W'(LOAD_VAL);
        end else if (en && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = en && !load && (cnt_q == W'(1));

endmodule

// File: rtl/vend_ctrl.sv
// Vending sequencer: coin credit, price check, dispenser req/ack, coin-by-coin change payout.
// All outputs registered; every input event shows on the outputs one cycle later.
// Coins are rejected outside IDLE/CREDIT; req stays high until the matching ack is sampled.
module vend_ctrl
    import vend_ctrl_pkg::*;
#(
    parameter int CREDIT_W     = 4,
    parameter int MAX_CREDIT   = 10,
    parameter int PRICE0       = PRICE0_DEF,
    parameter int PRICE1       = PRICE1_DEF,
    parameter int PRICE2       = PRICE2_DEF,
    parameter int PRICE3       = PRICE3_DEF,
    parameter int ACK_TIMEOUT  = 64,
    parameter int IDLE_TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       rst,
    vend_ctrl_if.master bus
);
    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] price_q, price_d;
    logic [1:0]          disp_id_q, disp_id_d;
    logic                disp_req_q, disp_req_d;
    logic                chg_req_q, chg_req_d;
    logic                chg_type_q, chg_type_d;
    logic                coin_reject_q, coin_reject_d;
    logic                insufficient_q, insufficient_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;

    logic [1:0]          add;
    logic                coin, coin_ok, sel_ok;
    logic [CREDIT_W:0]   sum, credit_plus;
    logic [CREDIT_W-1:0] price_sel;
    logic                ack_load, ack_expire, idle_load, idle_expire;

    assign add  = coin_units(bus.in5, bus.in10);
    assign coin = bus.in5 | bus.in10;
    assign sum  = {1'b0, credit_q} + (CREDIT_W+1)'(add);

    // A coin is kept only while taking money and only if it stays under the ceiling.
    assign coin_ok = coin && (state_q == ST_IDLE || state_q == ST_CREDIT)
                     && (sum <= (CREDIT_W+1)'(MAX_CREDIT));
    assign credit_plus = coin_ok ? sum : {1'b0, credit_q};
    assign sel_ok      = credit_q >= price_sel;

    // Timer loads are kept independent of the expire outputs to avoid a combinational loop.
    assign ack_load  = (state_q == ST_CREDIT) && bus.sel_valid && sel_ok;
    assign idle_load = (state_q == ST_IDLE && coin_ok)
                       || (state_q == ST_CREDIT && (coin_ok || bus.sel_valid));

    // Price lookup for the product being selected.
    always_comb begin
        price_sel = CREDIT_W'(PRICE0);
        case (bus.sel_id)
            2'd1:    price_sel = CREDIT_W'(PRICE1);
            2'd2:    price_sel = CREDIT_W'(PRICE2);
            2'd3:    price_sel = CREDIT_W'(PRICE3);
            default: price_sel = CREDIT_W'(PRICE0);
        endcase
    end

    // Next-state and next-output computation for the whole controller.
    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        price_d        = price_q;
        disp_id_d      = disp_id_q;
        disp_req_d     = disp_req_q;
        chg_req_d      = chg_req_q;
        chg_type_d     = chg_type_q;
        coin_reject_d  = coin && !coin_ok;
        insufficient_d = 1'b0;
        err_d          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // No credit yet, so any selection is refused; cancel has nothing to refund.
                insufficient_d = bus.sel_valid;
                if (coin_ok) begin
                    credit_d = credit_plus[CREDIT_W-1:0];
                    state_d  = ST_CREDIT;
                end
            end
            ST_CREDIT: begin
                credit_d = credit_plus[CREDIT_W-1:0];
                if (bus.sel_valid && sel_ok) begin
                    // Price is checked against the old credit; a same-cycle coin still counts.
                    credit_d   = CREDIT_W'(credit_plus - {1'b0, price_sel});
                    price_d    = price_sel;
                    disp_id_d  = bus.sel_id;
                    disp_req_d = 1'b1;
                    state_d    = ST_DISPENSE;
                end else begin
                    insufficient_d = bus.sel_valid;
                    if (bus.cancel || idle_expire) begin
                        state_d    = ST_CHANGE;
                        chg_req_d  = 1'b1;
                        chg_type_d = credit_d >= CREDIT_W'(2);
                    end
                end
            end
            ST_DISPENSE: begin
                if (bus.disp_ack) begin
                    disp_req_d = 1'b0;
                    if (credit_q != '0) begin
                        state_d    = ST_CHANGE;
                        chg_req_d  = 1'b1;
                        chg_type_d = credit_q >= CREDIT_W'(2);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (ack_expire) begin
                    // Motor never answered: give the price back and refund everything.
                    disp_req_d = 1'b0;
                    err_d      = 1'b1;
                    credit_d   = credit_q + price_q;
                    state_d    = ST_CHANGE;
                    chg_req_d  = 1'b1;
                    chg_type_d = credit_d >= CREDIT_W'(2);
                end
            end
            ST_CHANGE: begin
                if (chg_req_q && bus.chg_ack) begin
                    credit_d  = credit_q - (chg_type_q ? CREDIT_W'(2) : CREDIT_W'(1));
                    chg_req_d = 1'b0;
                    if (credit_d == '0) begin
                        state_d = ST_IDLE;
                    end
                end else if (!chg_req_q) begin
                    // One idle cycle after each coin, then ask for the next one.
                    chg_req_d  = 1'b1;
                    chg_type_d = credit_q >= CREDIT_W'(2);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_DISPENSE) || (state_d == ST_CHANGE);
    end

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            credit_q       <= '0;
            price_q        <= '0;
            disp_id_q      <= '0;
            disp_req_q     <= 1'b0;
            chg_req_q      <= 1'b0;
            chg_type_q     <= 1'b0;
            coin_reject_q  <= 1'b0;
            insufficient_q <= 1'b0;
            err_q          <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            price_q        <= price_d;
            disp_id_q      <= disp_id_d;
            disp_req_q     <= disp_req_d;
            chg_req_q      <= chg_req_d;
            chg_type_q     <= chg_type_d;
            coin_reject_q  <= coin_reject_d;
            insufficient_q <= insufficient_d;
            err_q          <= err_d;
            busy_q         <= busy_d;
        end
    end

    vend_timer #(.LOAD_VAL(ACK_TIMEOUT)) u_ack_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (ack_load),
        .en     (state_q == ST_DISPENSE),
        .expire (ack_expire)
    );

    vend_timer #(.LOAD_VAL(IDLE_TIMEOUT)) u_idle_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (idle_load),
        .en     (state_q == ST_CREDIT),
        .expire (idle_expire)
    );

    assign bus.credit       = credit_q;
    assign bus.disp_req     = disp_req_q;
    assign bus.disp_id      = disp_id_q;
    assign bus.chg_req      = chg_req_q;
    assign bus.chg_type     = chg_type_q;
    assign bus.coin_reject  = coin_reject_q;
    assign bus.insufficient = insufficient_q;
    assign bus.err          = err_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// Bench for vend_ctrl: vector table, directed corner sequences, random run against a credit model.
// Inputs are driven 1 time unit after the rising edge and outputs are sampled there too.
// Acks are only returned while the matching request is seen high.
module tb_vend_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    vend_ctrl_if #(.CREDIT_W(4)) bus ();

    vend_ctrl #(
        .CREDIT_W(4), .MAX_CREDIT(10),
        .PRICE0(3), .PRICE1(4), .PRICE2(5), .PRICE3(6),
        .ACK_TIMEOUT(64), .IDLE_TIMEOUT(1000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic saw_chg = 1'b0;

    localparam int PH_OPEN = 0, PH_DISP = 1, PH_REFUND = 2;
    int price_tab[4] = '{3, 4, 5, 6};

    typedef struct {
        int in5, in10, sel, id, cancel, dack, cack;
        int credit, rej, ins, dreq, creq, busy;
    } vec_t;
    vec_t tab[17];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_in();
        bus.in5 = 1'b0; bus.in10 = 1'b0; bus.sel_valid = 1'b0; bus.sel_id = 2'd0;
        bus.cancel = 1'b0; bus.disp_ack = 1'b0; bus.chg_ack = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.chg_req) saw_chg = 1'b1;
    endtask

    task automatic apply(input int in5, input int in10, input int sel, input int id,
                         input int cancel, input int dack, input int cack);
        bus.in5 = (in5 != 0); bus.in10 = (in10 != 0); bus.sel_valid = (sel != 0);
        bus.sel_id = 2'(id); bus.cancel = (cancel != 0);
        bus.disp_ack = (dack != 0); bus.chg_ack = (cack != 0);
        tick();
        clear_in();
    endtask

    // Pays out change until idle; seq records coin types as digits (2 = 10-coin, 1 = 5-coin).
    task automatic drain(output int seq);
        seq = 0;
        for (int k = 0; k < 60; k++) begin
            if (!bus.busy) break;
            if (bus.chg_req) begin
                seq = seq * 10 + (bus.chg_type ? 2 : 1);
                apply(0, 0, 0, 0, 0, 0, 1);
            end else begin
                tick();
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, seq;
        int m_credit, m_phase, m_id, add, newc;
        logic coin, ok;
        int exp_rej, exp_ins;

        // in5,in10,sel,id,cancel,dack,cack | credit,rej,ins,dreq,creq,busy
        tab[0]  = '{0,0,0,0,0,1,1,  0,0,0,0,0,0};
        tab[1]  = '{0,0,1,0,0,0,0,  0,0,1,0,0,0};
        tab[2]  = '{1,0,0,0,0,0,0,  1,0,0,0,0,0};
        tab[3]  = '{0,1,0,0,0,0,0,  3,0,0,0,0,0};
        tab[4]  = '{0,0,1,1,0,0,0,  3,0,1,0,0,0};
        tab[5]  = '{1,1,0,0,0,0,0,  6,0,0,0,0,0};
        tab[6]  = '{1,1,0,0,0,0,0,  9,0,0,0,0,0};
        tab[7]  = '{0,1,0,0,0,0,0,  9,1,0,0,0,0};
        tab[8]  = '{1,0,0,0,0,0,0, 10,0,0,0,0,0};
        tab[9]  = '{1,0,0,0,0,0,0, 10,1,0,0,0,0};
        tab[10] = '{0,0,1,3,0,0,0,  4,0,0,1,0,1};
        tab[11] = '{1,0,0,0,0,0,0,  4,1,0,1,0,1};
        tab[12] = '{0,0,1,0,1,0,0,  4,0,0,1,0,1};
        tab[13] = '{0,0,0,0,0,1,0,  4,0,0,0,1,1};
        tab[14] = '{0,0,0,0,0,0,1,  2,0,0,0,0,1};
        tab[15] = '{0,0,0,0,0,0,0,  2,0,0,0,1,1};
        tab[16] = '{0,0,0,0,0,0,1,  0,0,0,0,0,0};

        // Reset state
        clear_in();
        rst = 1'b1;
        tick(); tick();
        check("rst_credit", int'(bus.credit), 0);
        check("rst_disp_req", int'(bus.disp_req), 0);
        check("rst_chg_req", int'(bus.chg_req), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_err", int'(bus.err), 0);
        check("rst_reject", int'(bus.coin_reject), 0);
        rst = 1'b0;
        tick();

        // Vector table
        for (int i = 0; i < 17; i++) begin
            apply(tab[i].in5, tab[i].in10, tab[i].sel, tab[i].id,
                  tab[i].cancel, tab[i].dack, tab[i].cack);
            check($sformatf("vec%0d_credit", i), int'(bus.credit), tab[i].credit);
            check($sformatf("vec%0d_reject", i), int'(bus.coin_reject), tab[i].rej);
            check($sformatf("vec%0d_insuff", i), int'(bus.insufficient), tab[i].ins);
            check($sformatf("vec%0d_disp_req", i), int'(bus.disp_req), tab[i].dreq);
            check($sformatf("vec%0d_chg_req", i), int'(bus.chg_req), tab[i].creq);
            check($sformatf("vec%0d_busy", i), int'(bus.busy), tab[i].busy);
        end

        // Exact payment: no change cycle at all
        saw_chg = 1'b0;
        apply(0, 1, 0, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0, 0);
        apply(0, 0, 1, 0, 0, 0, 0);
        check("exact_disp_req", int'(bus.disp_req), 1);
        check("exact_disp_id", int'(bus.disp_id), 0);
        check("exact_credit", int'(bus.credit), 0);
        tick(); tick(); tick();
        check("exact_req_held", int'(bus.disp_req), 1);
        apply(0, 0, 0, 0, 0, 1, 0);
        check("exact_req_drop", int'(bus.disp_req), 0);
        check("exact_idle", int'(bus.busy), 0);
        tick(); tick();
        check("exact_no_chg", int'(saw_chg), 0);

        // Overpayment: one 10-coin back
        apply(0, 1, 0, 0, 0, 0, 0);
        apply(0, 1, 0, 0, 0, 0, 0);
        apply(0, 1, 0, 0, 0, 0, 0);
        check("over_credit6", int'(bus.credit), 6);
        apply(0, 0, 1, 1, 0, 0, 0);
        check("over_credit2", int'(bus.credit), 2);
        check("over_disp_id", int'(bus.disp_id), 1);
        apply(0, 0, 0, 0, 0, 1, 0);
        check("over_chg_req", int'(bus.chg_req), 1);
        check("over_chg_type", int'(bus.chg_type), 1);
        apply(0, 0, 0, 0, 0, 0, 1);
        check("over_credit0", int'(bus.credit), 0);
        check("over_idle", int'(bus.busy), 0);

        // Dispense fault: disp_req lasts exactly ACK_TIMEOUT cycles, then full refund
        apply(0, 1, 0, 0, 0, 0, 0);
        apply(0, 1, 0, 0, 0, 0, 0);
        apply(0, 0, 1, 1, 0, 0, 0);
        n = 1;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (!bus.disp_req) break;
            n++;
        end
        check("fault_req_cycles", n, 64);
        check("fault_err", int'(bus.err), 1);
        check("fault_credit", int'(bus.credit), 4);
        check("fault_chg_type", int'(bus.chg_type), 1);
        tick();
        check("fault_err_pulse", int'(bus.err), 0);
        drain(seq);
        check("fault_refund_seq", seq, 22);
        check("fault_credit_end", int'(bus.credit), 0);

        // Cancel with credit 3: 10-coin then 5-coin
        apply(0, 1, 0, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 1, 0, 0);
        check("cancel_busy", int'(bus.busy), 1);
        check("cancel_credit", int'(bus.credit), 3);
        drain(seq);
        check("cancel_seq", seq, 21);
        check("cancel_idle", int'(bus.busy), 0);

        // Inactivity refund after IDLE_TIMEOUT cycles
        apply(1, 0, 0, 0, 0, 0, 0);
        n = 0;
        for (int k = 0; k < 1100; k++) begin
            if (bus.busy) break;
            tick();
            n++;
        end
        check("idle_timeout_cycles", n, 1000);
        drain(seq);
        check("idle_refund_seq", seq, 1);

        // Reset in the middle of a payout
        apply(0, 1, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 0, 1, 0, 0);
        check("rstmid_pre_chg_req", int'(bus.chg_req), 1);
        check("rstmid_pre_credit", int'(bus.credit), 2);
        rst = 1'b1;
        #1;
        check("rstmid_chg_req", int'(bus.chg_req), 0);
        check("rstmid_credit", int'(bus.credit), 0);
        check("rstmid_busy", int'(bus.busy), 0);
        tick();
        rst = 1'b0;
        tick();
        apply(1, 0, 0, 0, 0, 0, 0);
        check("rstmid_after_credit", int'(bus.credit), 1);
        check("rstmid_after_busy", int'(bus.busy), 0);
        apply(0, 0, 0, 0, 1, 0, 0);
        drain(seq);
        check("rstmid_refund_seq", seq, 1);

        // Random traffic against a credit/phase model
        m_credit = 0; m_phase = PH_OPEN; m_id = 0;
        for (int c = 0; c < 3000; c++) begin
            bus.in5 = ($urandom % 6) == 0;
            bus.in10 = ($urandom % 6) == 0;
            bus.sel_valid = ($urandom % 7) == 0;
            bus.sel_id = 2'($urandom % 4);
            bus.cancel = ($urandom % 25) == 0;
            bus.disp_ack = bus.disp_req ? (($urandom % 3) == 0) : (($urandom % 10) == 0);
            if (m_phase == PH_REFUND) bus.chg_ack = bus.chg_req && (($urandom % 2) == 0);
            else bus.chg_ack = ($urandom % 10) == 0;

            add = (bus.in5 ? 1 : 0) + (bus.in10 ? 2 : 0);
            coin = bus.in5 | bus.in10;
            exp_rej = 0; exp_ins = 0;
            if (m_phase == PH_OPEN) begin
                ok = coin && (m_credit + add <= 10);
                exp_rej = (coin && !ok) ? 1 : 0;
                newc = m_credit + (ok ? add : 0);
                if (bus.sel_valid) begin
                    if (m_credit >= price_tab[bus.sel_id]) begin
                        newc = newc - price_tab[bus.sel_id];
                        m_id = int'(bus.sel_id);
                        m_phase = PH_DISP;
                    end else begin
                        exp_ins = 1;
                    end
                end
                if (m_phase == PH_OPEN && bus.cancel && m_credit > 0) m_phase = PH_REFUND;
                m_credit = newc;
            end else if (m_phase == PH_DISP) begin
                exp_rej = coin ? 1 : 0;
                if (bus.disp_ack) m_phase = (m_credit > 0) ? PH_REFUND : PH_OPEN;
            end else begin
                exp_rej = coin ? 1 : 0;
                if (bus.chg_ack) begin
                    m_credit = m_credit - ((m_credit >= 2) ? 2 : 1);
                    if (m_credit == 0) m_phase = PH_OPEN;
                end
            end

            tick();
            clear_in();
            check("rnd_credit", int'(bus.credit), m_credit);
            check("rnd_reject", int'(bus.coin_reject), exp_rej);
            check("rnd_insuff", int'(bus.insufficient), exp_ins);
            check("rnd_busy", int'(bus.busy), (m_phase != PH_OPEN) ? 1 : 0);
            check("rnd_disp_req", int'(bus.disp_req), (m_phase == PH_DISP) ? 1 : 0);
            check("rnd_err", int'(bus.err), 0);
            if (m_phase == PH_DISP) check("rnd_disp_id", int'(bus.disp_id), m_id);
            if (bus.chg_req) check("rnd_chg_type", int'(bus.chg_type), (m_credit >= 2) ? 1 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
